// File: rtl/mii_rx_parser_if.sv
// mii_rx_parser_if
//   Bundles the 64-bit MII receive word and the realigned frame output of
//   mii_rx_parser.
//   master : drives the MII word (i_*) and sinks the frame output (o_*)
//   slave  : the parser; sinks the MII word and drives the frame output
//   i_mii_rx_d  64  MII data, lane k = bits [8k+7:8k], lane 0 first on wire
//   i_mii_rx_c   8  per-lane control flag
//   i_valid      1  qualifies i_mii_rx_d / i_mii_rx_c
//   o_data      64  payload, frame byte 8m+k in lane k
//   o_keep       8  valid-lane mask, contiguous from lane 0
//   o_valid      1  one-cycle pulse per output word
//   o_sop/o_eop  1  first / last word of frame
//   o_err        1  frame error, valid with o_eop
//   o_frame_len 16  frame byte count, valid with o_eop
interface mii_rx_parser_if;
    logic [63:0] i_mii_rx_d;
    logic [7:0]  i_mii_rx_c;
    logic        i_valid;
    logic [63:0] o_data;
    logic [7:0]  o_keep;
    logic        o_valid;
    logic        o_sop;
    logic        o_eop;
    logic        o_err;
    logic [15:0] o_frame_len;

    modport master (
        output i_mii_rx_d, i_mii_rx_c, i_valid,
        input  o_data, o_keep, o_valid, o_sop, o_eop, o_err, o_frame_len
    );

    modport slave (
        input  i_mii_rx_d, i_mii_rx_c, i_valid,
        output o_data, o_keep, o_valid, o_sop, o_eop, o_err, o_frame_len
    );
endinterface

// File: rtl/mii_rx_parser.sv
// mii_rx_parser
//   Parses 8-lane 64-bit MII words: finds the start (0xFB, lane 0) and the
//   terminate (0xFD, any lane), strips delimiters and idles, realigns the
//   payload so frame byte 0 lands in lane 0, and emits 8-byte words with
//   keep, SOP/EOP, frame length and error status. All outputs registered.
//   Ports:
//     clk    in  rising-edge clock
//     i_rst  in  asynchronous active-high reset
//     bus    slave modport of mii_rx_parser_if (MII in, frame out)
//   Parameters:
//     USE_CTRL  1: lane is control only when its control bit is set
//               0: classify by byte value (0x07, 0xFB, 0xFD, 0xFE)
//     MIN_LEN / MAX_LEN  legal frame length range, delimiters excluded

// Per-lane character classifier.
//   d        in  lane byte
//   c        in  lane control flag
//   is_ctrl  out lane carries a control character
//   is_term  out lane carries the terminate character
module mii_lane_class #(
    parameter bit USE_CTRL = 1'b1
) (
    input  logic [7:0] d,
    input  logic       c,
    output logic       is_ctrl,
    output logic       is_term
);
    logic by_value;

    assign by_value = (d == 8'h07) || (d == 8'hFB) || (d == 8'hFD) || (d == 8'hFE);
    assign is_ctrl  = USE_CTRL ? c : by_value;
    assign is_term  = is_ctrl && (d == 8'hFD);
endmodule

module mii_rx_parser #(
    parameter bit USE_CTRL = 1'b1,
    parameter int MIN_LEN  = 64,
    parameter int MAX_LEN  = 1518
) (
    input  logic            clk,
    input  logic            i_rst,
    mii_rx_parser_if.slave  bus
);
    localparam int LANES = 8;

    typedef enum logic [1:0] {IDLE, DATA, FLUSH} state_t;

    state_t      state, state_nx;
    logic [55:0] held, held_nx;        // lanes 1-7 of the previous word
    logic [15:0] cnt, cnt_nx;          // frame bytes seen so far, saturating
    logic [2:0]  fl_j, fl_j_nx;        // terminate lane that led into FLUSH
    logic [15:0] fl_len, fl_len_nx;
    logic        fl_err, fl_err_nx;
    logic        sop_pend, sop_pend_nx; // next emitted word is the first of a frame

    logic [63:0] data_nx, data_r;
    logic [7:0]  keep_nx, keep_r;
    logic        valid_nx, valid_r;
    logic        sop_nx, sop_r;
    logic        eop_nx, eop_r;
    logic        err_nx, err_r;
    logic [15:0] len_nx, len_r;

    logic [LANES-1:0] is_ctrl, is_term;
    logic             has_ctrl, first_term, start_w;
    logic [2:0]       first_j;
    logic [16:0]      cnt_p8, term_sum;
    logic [63:0]      d;

    assign d = bus.i_mii_rx_d;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        mii_lane_class #(.USE_CTRL(USE_CTRL)) u_lane (
            .d       (bus.i_mii_rx_d[8*k +: 8]),
            .c       (bus.i_mii_rx_c[k]),
            .is_ctrl (is_ctrl[k]),
            .is_term (is_term[k])
        );
    end

    // Lowest-numbered control lane decides how the word is treated.
    always_comb begin
        first_j = 3'd0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (is_ctrl[k]) first_j = 3'(k);
        end
    end

    assign has_ctrl   = |is_ctrl;
    assign first_term = is_term[first_j];
    assign start_w    = is_ctrl[0] && (d[7:0] == 8'hFB);

    // 17-bit sums so saturation and the length range checks see overflow.
    assign cnt_p8   = {1'b0, cnt} + 17'd8;
    assign term_sum = {1'b0, cnt} + {14'd0, first_j};

    function automatic logic [15:0] sat16(input logic [16:0] v);
        return v[16] ? 16'hFFFF : v[15:0];
    endfunction

    function automatic logic len_bad(input logic [16:0] v);
        return (v < 17'(MIN_LEN)) || (v > 17'(MAX_LEN));
    endfunction

    always_comb begin
        state_nx    = state;
        held_nx     = held;
        cnt_nx      = cnt;
        fl_j_nx     = fl_j;
        fl_len_nx   = fl_len;
        fl_err_nx   = fl_err;
        sop_pend_nx = sop_pend;
        data_nx     = '0;
        keep_nx     = '0;
        valid_nx    = 1'b0;
        sop_nx      = 1'b0;
        eop_nx      = 1'b0;
        err_nx      = 1'b0;
        len_nx      = '0;

        case (state)
            IDLE: begin
                if (bus.i_valid && start_w) begin
                    held_nx     = d[63:8];
                    cnt_nx      = 16'd7;
                    sop_pend_nx = 1'b1;
                    state_nx    = DATA;
                end
            end

            DATA: begin
                if (bus.i_valid) begin
                    valid_nx    = 1'b1;
                    sop_nx      = sop_pend;
                    sop_pend_nx = 1'b0;
                    if (!has_ctrl) begin
                        data_nx = {d[7:0], held};
                        keep_nx = 8'hFF;
                        held_nx = d[63:8];
                        cnt_nx  = sat16(cnt_p8);
                    end else if (first_term) begin
                        if (first_j == 3'd0) begin
                            data_nx  = {8'h00, held};
                            keep_nx  = 8'h7F;
                            eop_nx   = 1'b1;
                            err_nx   = len_bad(term_sum);
                            len_nx   = sat16(term_sum);
                            state_nx = IDLE;
                        end else if (first_j == 3'd1) begin
                            data_nx  = {d[7:0], held};
                            keep_nx  = 8'hFF;
                            eop_nx   = 1'b1;
                            err_nx   = len_bad(term_sum);
                            len_nx   = sat16(term_sum);
                            state_nx = IDLE;
                        end else begin
                            // Tail bytes (lanes 1..j-1) go out next cycle.
                            data_nx   = {d[7:0], held};
                            keep_nx   = 8'hFF;
                            held_nx   = d[63:8];
                            fl_j_nx   = first_j;
                            fl_len_nx = sat16(term_sum);
                            fl_err_nx = len_bad(term_sum);
                            state_nx  = FLUSH;
                        end
                    end else begin
                        // Stray control (or a new start): close on held bytes.
                        data_nx  = {8'h00, held};
                        keep_nx  = 8'h7F;
                        eop_nx   = 1'b1;
                        err_nx   = 1'b1;
                        len_nx   = cnt;
                        state_nx = IDLE;
                        if (start_w) begin
                            held_nx     = d[63:8];
                            cnt_nx      = 16'd7;
                            sop_pend_nx = 1'b1;
                            state_nx    = DATA;
                        end
                    end
                end
            end

            FLUSH: begin
                valid_nx    = 1'b1;
                sop_nx      = sop_pend;
                sop_pend_nx = 1'b0;
                data_nx     = {8'h00, held};
                keep_nx     = ~(8'hFF << (fl_j - 3'd1));
                eop_nx      = 1'b1;
                err_nx      = fl_err;
                len_nx      = fl_len;
                state_nx    = IDLE;
                // Back-to-back start is accepted while the tail drains.
                if (bus.i_valid && start_w) begin
                    held_nx     = d[63:8];
                    cnt_nx      = 16'd7;
                    sop_pend_nx = 1'b1;
                    state_nx    = DATA;
                end
            end

            default: state_nx = IDLE;
        endcase

        // Lanes outside keep are driven as zero.
        for (int k = 0; k < LANES; k++) begin
            if (!keep_nx[k]) data_nx[8*k +: 8] = 8'h00;
        end
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            held     <= '0;
            cnt      <= '0;
            fl_j     <= '0;
            fl_len   <= '0;
            fl_err   <= 1'b0;
            sop_pend <= 1'b0;
            data_r   <= '0;
            keep_r   <= '0;
            valid_r  <= 1'b0;
            sop_r    <= 1'b0;
            eop_r    <= 1'b0;
            err_r    <= 1'b0;
            len_r    <= '0;
        end else begin
            state    <= state_nx;
            held     <= held_nx;
            cnt      <= cnt_nx;
            fl_j     <= fl_j_nx;
            fl_len   <= fl_len_nx;
            fl_err   <= fl_err_nx;
            sop_pend <= sop_pend_nx;
            data_r   <= data_nx;
            keep_r   <= keep_nx;
            valid_r  <= valid_nx;
            sop_r    <= sop_nx;
            eop_r    <= eop_nx;
            err_r    <= err_nx;
            len_r    <= len_nx;
        end
    end

    assign bus.o_data      = data_r;
    assign bus.o_keep      = keep_r;
    assign bus.o_valid     = valid_r;
    assign bus.o_sop       = sop_r;
    assign bus.o_eop       = eop_r;
    assign bus.o_err       = err_r;
    assign bus.o_frame_len = len_r;
endmodule

// File: tb/tb_mii_rx_parser.sv
// tb_mii_rx_parser
//   Directed bench for mii_rx_parser. Two instances share clock and reset:
//   dut_a uses control flags (MIN_LEN 8), dut_b classifies by byte value
//   with control held 0xFF (MIN_LEN = MAX_LEN = 64). Each step drives one
//   word, clocks it, and checks the registered output 1 time unit later.
module tb_mii_rx_parser;
    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    mii_rx_parser_if ifa ();
    mii_rx_parser_if ifb ();

    mii_rx_parser #(.USE_CTRL(1'b1), .MIN_LEN(8), .MAX_LEN(1518)) dut_a (
        .clk(clk), .i_rst(rst), .bus(ifa)
    );
    mii_rx_parser #(.USE_CTRL(1'b0), .MIN_LEN(64), .MAX_LEN(64)) dut_b (
        .clk(clk), .i_rst(rst), .bus(ifb)
    );

    // lanes k = b + k
    function automatic logic [63:0] seq8(input logic [7:0] b);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) w[8*k +: 8] = b + 8'(k);
        return w;
    endfunction

    // start in lane 0, payload b.. in lanes 1-7
    function automatic logic [63:0] startw(input logic [7:0] b);
        logic [63:0] w;
        w = seq8(b);
        return {w[55:0], 8'hFB};
    endfunction

    // payload b.. in lanes 0..j-1, terminate in lane j, idles above
    function automatic logic [63:0] termw(input logic [7:0] b, input int j);
        logic [63:0] w;
        for (int k = 0; k < 8; k++)
            w[8*k +: 8] = (k < j) ? b + 8'(k) : ((k == j) ? 8'hFD : 8'h07);
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cmp(input string tag,
                       input logic ov, os, oe, oerr, input logic [7:0] ok,
                       input logic [63:0] od, input logic [15:0] ol,
                       input logic ev, es, ee, eerr, input logic [7:0] ek,
                       input logic [63:0] ed, input logic [15:0] el);
        logic [63:0] m;
        for (int k = 0; k < 8; k++) m[8*k +: 8] = {8{ek[k]}};
        chk({tag, ".valid"}, 64'(ov), 64'(ev));
        if (ev) begin
            chk({tag, ".sop"},  64'(os), 64'(es));
            chk({tag, ".eop"},  64'(oe), 64'(ee));
            chk({tag, ".keep"}, 64'(ok), 64'(ek));
            chk({tag, ".data"}, od & m, ed & m);
            if (ee) begin
                chk({tag, ".err"}, 64'(oerr), 64'(eerr));
                chk({tag, ".len"}, 64'(ol), 64'(el));
            end
        end
    endtask

    task automatic xa(input string tag, input logic ev, es, ee, eerr,
                      input logic [7:0] ek, input logic [63:0] ed, input logic [15:0] el);
        cmp(tag, ifa.o_valid, ifa.o_sop, ifa.o_eop, ifa.o_err, ifa.o_keep, ifa.o_data,
            ifa.o_frame_len, ev, es, ee, eerr, ek, ed, el);
    endtask

    task automatic xb(input string tag, input logic ev, es, ee, eerr,
                      input logic [7:0] ek, input logic [63:0] ed, input logic [15:0] el);
        cmp(tag, ifb.o_valid, ifb.o_sop, ifb.o_eop, ifb.o_err, ifb.o_keep, ifb.o_data,
            ifb.o_frame_len, ev, es, ee, eerr, ek, ed, el);
    endtask

    task automatic nva(input string tag);
        xa(tag, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 16'h0);
    endtask

    task automatic nvb(input string tag);
        xb(tag, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 64'h0, 16'h0);
    endtask

    task automatic all_zero(input string tag);
        chk({tag, ".a.valid"}, 64'(ifa.o_valid), 64'h0);
        chk({tag, ".a.sop"},   64'(ifa.o_sop),   64'h0);
        chk({tag, ".a.eop"},   64'(ifa.o_eop),   64'h0);
        chk({tag, ".a.err"},   64'(ifa.o_err),   64'h0);
        chk({tag, ".a.keep"},  64'(ifa.o_keep),  64'h0);
        chk({tag, ".a.data"},  ifa.o_data,       64'h0);
        chk({tag, ".a.len"},   64'(ifa.o_frame_len), 64'h0);
        chk({tag, ".b.valid"}, 64'(ifb.o_valid), 64'h0);
        chk({tag, ".b.data"},  ifb.o_data,       64'h0);
        chk({tag, ".b.len"},   64'(ifb.o_frame_len), 64'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sa(input logic [63:0] d, input logic [7:0] c);
        ifa.i_mii_rx_d = d;
        ifa.i_mii_rx_c = c;
        ifa.i_valid    = 1'b1;
        tick();
        ifa.i_valid    = 1'b0;
    endtask

    task automatic sb(input logic [63:0] d, input logic [7:0] c);
        ifb.i_mii_rx_d = d;
        ifb.i_mii_rx_c = c;
        ifb.i_valid    = 1'b1;
        tick();
        ifb.i_valid    = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        ifa.i_mii_rx_d = '0; ifa.i_mii_rx_c = '0; ifa.i_valid = 1'b0;
        ifb.i_mii_rx_d = '0; ifb.i_mii_rx_c = 8'hFF; ifb.i_valid = 1'b0;
        tick(); tick();
        all_zero("reset");
        rst = 1'b0;
        tick();
        nva("post_reset");

        // 22-byte frame, bytes 0x00..0x15, terminate in lane 7
        sa(startw(8'h00), 8'h01);               nva("f22.start");
        sa(seq8(8'h07), 8'h00);
        xa("f22.w0", 1, 1, 0, 0, 8'hFF, seq8(8'h00), 0);
        sa(termw(8'h0F, 7), 8'h80);
        xa("f22.w1", 1, 0, 0, 0, 8'hFF, seq8(8'h08), 0);
        tick();
        xa("f22.w2", 1, 0, 1, 0, 8'h3F, seq8(8'h10), 16'd22);
        tick();                                 nva("f22.after");

        // start then terminate in lane 0: 7 bytes, below MIN_LEN
        sa(startw(8'h11), 8'h01);
        sa(termw(8'h00, 0), 8'hFF);
        xa("short7", 1, 1, 1, 1, 8'h7F, seq8(8'h11), 16'd7);

        // exactly MIN_LEN: terminate in lane 1
        sa(startw(8'h21), 8'h01);
        sa(termw(8'h28, 1), 8'hFE);
        xa("min8", 1, 1, 1, 0, 8'hFF, seq8(8'h21), 16'd8);

        // 0xFE control in lane 3 of the second data word
        sa(startw(8'h31), 8'h01);
        sa(seq8(8'h38), 8'h00);
        xa("fe.w0", 1, 1, 0, 0, 8'hFF, seq8(8'h31), 0);
        sa(64'h47464544FE424140, 8'h08);
        xa("fe.eop", 1, 0, 1, 1, 8'h7F, seq8(8'h39), 16'd15);
        sa(startw(8'h51), 8'h01);               nva("fe.restart");
        sa(seq8(8'h58), 8'h00);
        xa("fe.n0", 1, 1, 0, 0, 8'hFF, seq8(8'h51), 0);
        sa(termw(8'h60, 1), 8'hFE);
        xa("fe.n1", 1, 0, 1, 0, 8'hFF, seq8(8'h59), 16'd16);

        // terminate in lane 3 followed at once by a start
        sa(startw(8'h61), 8'h01);
        sa(termw(8'h68, 3), 8'hF8);
        xa("b2b.w0", 1, 1, 0, 0, 8'hFF, seq8(8'h61), 0);
        sa(startw(8'h71), 8'h01);
        xa("b2b.flush", 1, 0, 1, 0, 8'h03, seq8(8'h69), 16'd10);
        sa(seq8(8'h78), 8'h00);
        xa("b2b.n0", 1, 1, 0, 0, 8'hFF, seq8(8'h71), 0);
        sa(termw(8'h00, 0), 8'hFF);
        xa("b2b.n1", 1, 0, 1, 0, 8'h7F, seq8(8'h79), 16'd15);

        // start in lane 0 while a frame is open
        sa(startw(8'h81), 8'h01);
        sa(startw(8'h91), 8'h01);
        xa("fb.close", 1, 1, 1, 1, 8'h7F, seq8(8'h81), 16'd7);
        sa(termw(8'h98, 1), 8'hFE);
        xa("fb.next", 1, 1, 1, 0, 8'hFF, seq8(8'h91), 16'd8);

        // i_valid low holds state
        sa(startw(8'hA1), 8'h01);
        tick();                                 nva("hold.0");
        tick();                                 nva("hold.1");
        sa(termw(8'hA8, 1), 8'hFE);
        xa("hold.end", 1, 1, 1, 0, 8'hFF, seq8(8'hA1), 16'd8);

        // reset pulsed mid-frame
        sa(startw(8'hB1), 8'h01);
        sa(seq8(8'hB8), 8'h00);
        xa("rst.w0", 1, 1, 0, 0, 8'hFF, seq8(8'hB1), 0);
        rst = 1'b1;
        #1;
        all_zero("rst.async");
        tick();
        rst = 1'b0;
        sa(seq8(8'hC0), 8'h00);                 nva("rst.drop0");
        sa(termw(8'hC8, 1), 8'hFE);             nva("rst.drop1");
        sa(startw(8'hD1), 8'h01);               nva("rst.start");
        sa(termw(8'hD8, 1), 8'hFE);
        xa("rst.clean", 1, 1, 1, 0, 8'hFF, seq8(8'hD1), 16'd8);

        // dut_b: value-classified control, 64-byte frame (legal)
        sb(startw(8'h10), 8'hFF);               nvb("b64.start");
        for (int m = 0; m < 7; m++) begin
            sb(seq8(8'h17 + 8'(8 * m)), 8'hFF);
            xb("b64.w", 1, m == 0, 0, 0, 8'hFF, seq8(8'h10 + 8'(8 * m)), 0);
        end
        sb(termw(8'h4F, 1), 8'hFF);
        xb("b64.eop", 1, 0, 1, 0, 8'hFF, seq8(8'h48), 16'd64);

        // dut_b: 65-byte frame, one over MAX_LEN, ends through FLUSH
        sb(startw(8'h10), 8'hFF);
        for (int m = 0; m < 7; m++) begin
            sb(seq8(8'h17 + 8'(8 * m)), 8'hFF);
            xb("b65.w", 1, m == 0, 0, 0, 8'hFF, seq8(8'h10 + 8'(8 * m)), 0);
        end
        sb(termw(8'h4F, 2), 8'hFF);
        xb("b65.w7", 1, 0, 0, 0, 8'hFF, seq8(8'h48), 0);
        tick();
        xb("b65.flush", 1, 0, 1, 1, 8'h01, seq8(8'h50), 16'd65);
        tick();                                 nvb("b65.after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mii_rx_parser.md
# mii_rx_parser

Receive-side counterpart of the 64-bit MII frame generator. It accepts 8-lane, 64-bit MII words (data plus per-lane control flags) and finds the start (0xFB, lane 0) and terminate (0xFD, any lane) delimiters. It strips the delimiters and idles, realigns the payload so frame byte 0 sits in lane 0, and emits 8-byte-aligned words with byte-keep, SOP/EOP, frame length and error status. It sits between the PCS/MII loopback and the MAC-side frame checker in the verification datapath.

## Interface
- USE_CTRL, 1: 1 = a lane is a control character only when its i_mii_rx_c bit is set; 0 = ignore i_mii_rx_c and classify by byte value only (0x07, 0xFB, 0xFD, 0xFE are control). Use 0 when the upstream sources control as constant 0xFF.
- MIN_LEN, 64: minimum legal frame length in bytes (delimiters excluded).
- MAX_LEN, 1518: maximum legal frame length in bytes.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_mii_rx_d  in  64  MII data word, lane k = bits [8k+7:8k], lane 0 first on the wire.
- i_mii_rx_c  in  8  per-lane control flag, bit k for lane k.
- i_valid  in  1  qualifies i_mii_rx_d/i_mii_rx_c. When low, the word is ignored and all state holds.
- o_data  out  64  realigned payload, frame byte 8m+k in lane k.
- o_keep  out  8  valid-lane mask, contiguous from lane 0.
- o_valid  out  1  o_data/o_keep valid, one-cycle pulse per word.
- o_sop  out  1  first word of frame (with o_valid).
- o_eop  out  1  last word of frame (with o_valid).
- o_err  out  1  frame error, valid only with o_eop.
- o_frame_len  out  16  byte count of the frame, valid with o_eop, saturates at 0xFFFF.

## Operation
- FSM states: IDLE, DATA, FLUSH. Held register: 56 bits plus a 16-bit byte counter.
- IDLE:
  - Start word = lane 0 is 0xFB and is control. Load lanes 1-7 into held, counter=7, go to DATA. No output is produced.
  - Any other word is discarded, including a start character in lanes 1-7.
- DATA, normal data word (no control lanes):
  - Output {lane0, held} with keep 0xFF.
  - Load lanes 1-7 into held, counter += 8.
- DATA, terminate word (first control lane j is 0xFD; lanes 0..j-1 are data): frame length = counter + j.
  - j=0: output held, keep 0x7F, eop. Go to IDLE.
  - j=1: output {lane0, held}, keep 0xFF, eop. Go to IDLE.
  - j≥2: output {lane0, held}, keep 0xFF, no eop. Load lanes 1..j-1 into held, go to FLUSH.
- FLUSH (one cycle, independent of i_valid): output held lanes 0..j-2, keep = (1<<(j-1))-1, eop. Go to IDLE.
  - If a start word is accepted in the same cycle, it is loaded as in IDLE and the state goes to DATA. The flush output is still produced.
- o_sop: asserted on the first output word of each frame.
- Errors (o_err=1 on the eop word):
  - Any control lane in a DATA word other than a terminate as above, e.g. 0xFE or 0x07. Bytes before that lane are dropped and the word is treated as terminate at j=0 (held emitted, keep 0x7F).
  - 0xFB in lane 0 while in DATA: the current frame closes as j=0 with err, and the new frame is loaded as a start.
  - frame length < MIN_LEN or > MAX_LEN.
- Counter saturates at 0xFFFF. Exceeding MAX_LEN does not truncate; the frame runs to its terminate and is flagged.

## Timing
- Reset values: all outputs 0, state IDLE, held 0, counter 0.
- Reset asserted mid-frame: outputs clear immediately, the frame is dropped with no eop, and the following words are ignored until the next start.
- All outputs are registered. The output for an accepted word appears the cycle after acceptance. FLUSH output appears the cycle after the terminate output.
- Throughput is one word per cycle. There is no backpressure: the consumer must sink every o_valid word.
- i_valid low: no output is produced and state holds. In FLUSH the state still advances.

## Test plan
- 22-byte frame, bytes 0x00..0x15, MIN_LEN=8. Inputs: start word, word with bytes 7-14, word with bytes 15-21 in lanes 0-6 and 0xFD in lane 7. Outputs over 3 consecutive cycles:
  - bytes 0-7, keep 0xFF, sop
  - bytes 8-15, keep 0xFF
  - bytes 16-21, keep 0x3F, eop, len 22, err 0.
- Start word then 0xFD in lane 0 (MIN_LEN=64) -> one word, keep 0x7F, sop+eop, len 7, err 1.
- 0xFE control in lane 3 of the second data word -> eop word keep 0x7F, err 1. The next start is parsed normally.
- USE_CTRL=0, i_mii_rx_c held 0xFF, 64-byte frame -> 8 words of keep 0xFF then keep 0x7F? No: 64 bytes = 8 full words, last with eop, len 64, err 0.
- Terminate with j=3 immediately followed by a start word -> flush eop (keep 0x03) in the same cycle the new frame loads. The new frame's first output has sop with no lost word.
- i_rst pulsed during the DATA state -> all outputs 0 next edge. The following data words produce no output. A subsequent start word produces a clean frame.
